mux_scan_seq: RTL and testbench

- Parametrised, registered N-channel, W-bit multiplexer; next generation of the lab 2-to-1 single-bit mux.
- Adds a manual mode (switch-driven channel select) and an auto-scan mode that rotates through channels every DWELL clocks, with a pause/hold control.
- Drives LEDR/HEX display logic from switch-selected or rotating data sources in later labs.

---
 rtl/mux_scan_seq.sv | 107 ++++++++++
 tb/tb_mux_scan_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N-channel, W-bit multiplexer.
// In manual mode the channel comes from the switches. In scan mode the
// channel rotates every DWELL clocks, and hold pauses the rotation.
// mux_out and cur_ch update on the same edge, so they always describe the
// same channel.
module mux_scan_seq #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          mux_out,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      ch_tick
);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    // One bit wider than sel so that CHANNELS == 2**SEL_W still fits.
    localparam logic [SEL_W:0]   ch_limit   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] ch_last    = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] dwell_last = CNT_W'(DWELL - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_base, cnt_nxt;
    logic [SEL_W-1:0] ch_nxt;
    logic             tick_nxt;
    logic [WIDTH-1:0] data_nxt;

    // Next state, next channel, dwell count and tick, all taken from the next state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = MANUAL;
        ch_nxt    = cur_ch;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;

        if (mode) begin
            state_nxt = hold ? PAUSED : SCAN;
        end

        // A scan entered from manual always starts with a full dwell period.
        cnt_base = (state == MANUAL) ? '0 : cnt;

        case (state_nxt)
            MANUAL: begin
                cnt_nxt = '0;
                // Out-of-range selects are ignored, and the current channel stays.
                if ({1'b0, sel} < ch_limit) begin
                    ch_nxt = sel;
                end
            end
            SCAN: begin
                if (cnt_base == dwell_last) begin
                    cnt_nxt  = '0;
                    tick_nxt = 1'b1;
                    ch_nxt   = (cur_ch == ch_last) ? '0 : cur_ch + SEL_W'(1);
                end else begin
                    cnt_nxt = cnt_base + CNT_W'(1);
                end
            end
            default: begin
                // PAUSED: the counter and the channel stay frozen.
                cnt_nxt = cnt;
            end
        endcase

        data_nxt = data_in[ch_nxt*WIDTH +: WIDTH];
    end

    // Mode state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= MANUAL;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Datapath registers: dwell counter, channel index, output data and tick.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            cur_ch  <= '0;
            mux_out <= '0;
            ch_tick <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            cur_ch  <= ch_nxt;
            mux_out <= data_nxt;
            ch_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed self-checking bench for mux_scan_seq. The main instance has
// four channels and the small instance has three channels. Both use a
// dwell of 4 clocks. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge.
module tb_mux_scan_seq;

    logic        clock;
    logic        resetn;

    // Four-channel instance
    logic [15:0] data_in;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;
    logic [3:0]  mux_out;
    logic [1:0]  cur_ch;
    logic        ch_tick;

    // Three-channel instance
    logic [11:0] data_in3;
    logic [1:0]  sel3;
    logic        mode3;
    logic        hold3;
    logic [3:0]  mux_out3;
    logic [1:0]  cur_ch3;
    logic        ch_tick3;

    int checks = 0;
    int errors = 0;

    // Channel values for data_in = 16'hD3A5
    logic [3:0] ch_val [4] = '{4'h5, 4'hA, 4'h3, 4'hD};

    mux_scan_seq #(
        .WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(4), .CNT_W(3)
    ) dut (
        .clock(clock), .resetn(resetn), .data_in(data_in), .sel(sel),
        .mode(mode), .hold(hold), .mux_out(mux_out), .cur_ch(cur_ch),
        .ch_tick(ch_tick)
    );

    mux_scan_seq #(
        .WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(4), .CNT_W(3)
    ) dut3 (
        .clock(clock), .resetn(resetn), .data_in(data_in3), .sel(sel3),
        .mode(mode3), .hold(hold3), .mux_out(mux_out3), .cur_ch(cur_ch3),
        .ch_tick(ch_tick3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and stop on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Check all three outputs of the four-channel instance against a channel and a tick value.
    task automatic expect4(input string tag, input int ch, input logic tick);
        check({tag, ".cur_ch"}, cur_ch, ch);
        check({tag, ".mux_out"}, mux_out, ch_val[ch]);
        check({tag, ".ch_tick"}, ch_tick, tick);
    endtask

    initial begin
        int ch;

        resetn   = 1'b0;
        data_in  = 16'hD3A5;
        sel      = 2'd0;
        mode     = 1'b0;
        hold     = 1'b0;
        data_in3 = 12'h3A5;
        sel3     = 2'd0;
        mode3    = 1'b0;
        hold3    = 1'b0;

        // Reset state, checked before any clock edge
        #2;
        check("rst.mux_out", mux_out, 0);
        check("rst.cur_ch", cur_ch, 0);
        check("rst.ch_tick", ch_tick, 0);
        @(negedge clock);
        resetn = 1'b1;

        // Manual select, then a data change on the selected channel
        sel = 2'd2;
        step(1);
        expect4("man.sel2", 2, 1'b0);
        data_in = 16'hD7A5;
        step(1);
        check("man.ch2_7", mux_out, 4'h7);
        check("man.tick", ch_tick, 0);
        data_in = 16'hD3A5;
        step(1);
        expect4("man.restore", 2, 1'b0);

        // Scan from channel 2: advances on edges 4, 8 and 12
        mode = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            ch = (2 + k / 4) % 4;
            expect4($sformatf("scan.e%0d", k), ch, (k % 4) == 0);
        end

        // Hold two edges after an advance, for ten cycles
        step(2);
        expect4("hold.pre", 1, 1'b0);
        hold = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            expect4($sformatf("hold.e%0d", k), 1, 1'b0);
        end
        hold = 1'b0;
        step(1);
        expect4("resume.e1", 1, 1'b0);
        step(1);
        expect4("resume.e2", 2, 1'b1);

        // Switch to manual mid-dwell (counter 2), then return to scan
        step(2);
        sel  = 2'd0;
        mode = 1'b0;
        step(1);
        expect4("mswitch.man", 0, 1'b0);
        mode = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            expect4($sformatf("mswitch.e%0d", k), (k == 4) ? 1 : 0, k == 4);
        end

        // Reach counter 3 on channel 2, then assert reset between edges
        step(4);
        expect4("prerst.adv", 2, 1'b1);
        step(3);
        expect4("prerst.cnt3", 2, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("arst.mux_out", mux_out, 0);
        check("arst.cur_ch", cur_ch, 0);
        check("arst.ch_tick", ch_tick, 0);
        @(negedge clock);
        check("arst.held", cur_ch, 0);
        resetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            expect4($sformatf("rstscan.e%0d", k), (k == 4) ? 1 : 0, k == 4);
        end
        mode = 1'b0;

        // Three channels: out-of-range select is ignored and the scan wraps at 2
        sel3 = 2'd1;
        step(1);
        check("c3.sel1.cur_ch", cur_ch3, 1);
        check("c3.sel1.mux_out", mux_out3, 4'hA);
        sel3 = 2'd3;
        step(3);
        check("c3.sel3.cur_ch", cur_ch3, 1);
        check("c3.sel3.mux_out", mux_out3, 4'hA);
        check("c3.sel3.tick", ch_tick3, 0);
        mode3 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            ch = (1 + k / 4) % 3;
            check($sformatf("c3.scan.e%0d.cur_ch", k), cur_ch3, ch);
            check($sformatf("c3.scan.e%0d.mux_out", k), mux_out3, ch_val[ch]);
            check($sformatf("c3.scan.e%0d.tick", k), ch_tick3, (k % 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
